muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide engine that feeds the HiLo register. It captures two 32-bit operands from the register-file read ports, runs a radix-2 shift-add multiply or restore divide over 32 cycles, and presents a 64-bit {Hi,Lo} result with a one-cycle write-enable pulse that drives HiLoRegister's WriteEnable/WriteData directly. The datapath controller holds the PC using Busy.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the datapath and the multiply/divide unit.
//   start       - request, sampled only while the unit is idle
//   op          - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b        - multiplicand/dividend and multiplier/divisor
//   busy        - high while iterating
//   done        - one-cycle completion pulse
//   hilo_en     - HiLo write strobe, identical to done
//   hilo_write  - {Hi,Lo} result, held until the next completion
//   div_by_zero - pulses with done when a divide had b == 0
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        hilo_en;
  logic [63:0] hilo_write;
  logic        div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_en, hilo_write, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_en, hilo_write, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide feeding the HiLo register.
// Radix-2 shift-add multiply or restoring divide, one iteration per cycle for 32 cycles,
// then a one-cycle done/hilo_en pulse with the sign-corrected {Hi,Lo} result.
//   clk_i   - clock, all state on rising edge
//   rst_ni  - asynchronous active-low reset
//   bus_io  - muldiv_unit_if slave (start/op/a/b in; busy/done/hilo_en/hilo_write/div_by_zero out)
// Build option: MULDIV_DIV_EN enables the divider. Without it DIV/DIVU complete one cycle
// after acceptance with a zero result and no divide-by-zero flag.
module muldiv_unit (
  input  logic         clk_i,
  input  logic         rst_ni,
  muldiv_unit_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_res_q;   // negate product / quotient
  logic        neg_rem_q;   // remainder takes the dividend's sign
  logic [31:0] hi_q;        // product upper half / partial remainder
  logic [31:0] lo_q;        // multiplier then product lower half / dividend then quotient
  logic [31:0] mcand_q;     // multiplicand or divisor magnitude
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic [63:0] hilo_q;

  // Operand magnitudes for signed ops, raw values for unsigned ops.
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    signed_op = ~bus_io.op[0];
    a_neg     = signed_op & bus_io.a[31];
    b_neg     = signed_op & bus_io.b[31];
    abs_a     = a_neg ? (~bus_io.a + 32'd1) : bus_io.a;
    abs_b     = b_neg ? (~bus_io.b + 32'd1) : bus_io.b;
  end

  // One iteration of the active algorithm plus the sign fix-up used on the last one.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [63:0] fin;
`ifdef MULDIV_DIV_EN
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_rem;
  logic [63:0] div_next;
`endif

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    // {carry,acc} shifted right by one
    mul_next = {mul_sum, lo_q[31:1]};
`ifdef MULDIV_DIV_EN
    div_sh   = {hi_q, lo_q[31]};
    div_ok   = (div_sh >= {1'b0, mcand_q});
    // When the trial succeeds the difference is below the divisor, so 32 bits suffice.
    div_rem  = div_sh[31:0] - mcand_q;
    div_next = {(div_ok ? div_rem : div_sh[31:0]), lo_q[30:0], div_ok};
    step_next = is_div_q ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
    if (is_div_q) begin
      fin[31:0]  = neg_res_q ? (~step_next[31:0] + 32'd1) : step_next[31:0];
      fin[63:32] = neg_rem_q ? (~step_next[63:32] + 32'd1) : step_next[63:32];
    end else begin
      fin = neg_res_q ? (~step_next + 64'd1) : step_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mcand_q   <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hilo_q    <= 64'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
          if (bus_io.start) begin
            is_div_q  <= bus_io.op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            hi_q      <= 32'd0;
            cnt_q     <= 5'd31;
            if (bus_io.op[1]) begin
`ifdef MULDIV_DIV_EN
              lo_q    <= abs_a;
              mcand_q <= abs_b;
              if (bus_io.b == 32'd0) begin
                hilo_q  <= {bus_io.a, 32'hFFFF_FFFF};
                dbz_q   <= 1'b1;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                busy_q  <= 1'b1;
                state_q <= StRun;
              end
`else
              hilo_q  <= 64'd0;
              done_q  <= 1'b1;
              state_q <= StDone;
`endif
            end else begin
              lo_q    <= abs_b;
              mcand_q <= abs_a;
              busy_q  <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          {hi_q, lo_q} <= step_next;
          if (cnt_q == 5'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hilo_q  <= fin;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.hilo_en     = done_q;
  assign bus_io.hilo_write  = hilo_q;
  assign bus_io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one operation; optionally pulse a competing Start at RUN cycle `inject`.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject, output logic [63:0] res,
                        output logic dbz, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    res      = '0;
    dbz      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1 || n == inject + 1) bus.start = 1'b0;
      if (inject > 0 && n == inject) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n;
        res = bus.hilo_write;
        dbz = bus.div_by_zero;
        check_eq({tag, "_hilo_en"}, {63'd0, bus.hilo_en}, 64'd1);
        break;
      end
    end
    if (lat == 0) check_eq({tag, "_timeout_done"}, {63'd0, bus.done}, 64'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  logic [63:0] res;
  logic        dbz;
  int          lat;
  int          bcnt;
  int          cnt;
  int          d0;
  int          d1;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_hilo", bus.hilo_write, 64'd0);
    check_eq("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, dbz, lat, bcnt);
    check_eq("multu_max_res", res, 64'hFFFF_FFFE_0000_0001);
    check_eq("multu_max_lat", 64'(lat), 64'd33);
    check_eq("multu_max_busy", 64'(bcnt), 64'd32);
    repeat (3) @(negedge clk);
    check_eq("hilo_held", bus.hilo_write, 64'hFFFF_FFFE_0000_0001);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, res, dbz, lat, bcnt);
    check_eq("mult_neg_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0, res, dbz, lat, bcnt);
    check_eq("mult_min_res", res, 64'h4000_0000_0000_0000);
    run_op("multu_sh", 2'b01, 32'h1234_5678, 32'h10, 0, res, dbz, lat, bcnt);
    check_eq("multu_sh_res", res, 64'h0000_0001_2345_6780);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, res, dbz, lat, bcnt);
    check_eq("div_neg_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, res, dbz, lat, bcnt);
    check_eq("div_negb_res", res, 64'h0000_0001_FFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, res, dbz, lat, bcnt);
    check_eq("divu_zero_res", res, 64'h0000_0064_FFFF_FFFF);
    check_eq("divu_zero_dbz", {63'd0, dbz}, 64'd1);
    check_eq("divu_zero_lat", 64'(lat), 64'd1);
    check_eq("divu_zero_busy", 64'(bcnt), 64'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, dbz, lat, bcnt);
    check_eq("div_ovf_res", res, 64'h0000_0000_8000_0000);
    check_eq("div_ovf_dbz", {63'd0, dbz}, 64'd0);
    run_op("divu_7", 2'b11, 32'd100, 32'd7, 0, res, dbz, lat, bcnt);
    check_eq("divu_7_res", res, 64'h0000_0002_0000_000E);
    check_eq("divu_7_lat", 64'(lat), 64'd33);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, res, dbz, lat, bcnt);
    check_eq("divu_big_res", res, 64'h0000_0001_0000_0001);
`else
    run_op("div_off", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, res, dbz, lat, bcnt);
    check_eq("div_off_res", res, 64'd0);
    check_eq("div_off_lat", 64'(lat), 64'd1);
    run_op("divu_off_zero", 2'b11, 32'd100, 32'd0, 0, res, dbz, lat, bcnt);
    check_eq("divu_off_dbz", {63'd0, dbz}, 64'd0);
    check_eq("divu_off_res", res, 64'd0);
`endif

    // Competing Start during RUN must be ignored.
    run_op("ign", 2'b01, 32'd5, 32'd6, 10, res, dbz, lat, bcnt);
    check_eq("ign_res", res, 64'h0000_0000_0000_001E);
    check_eq("ign_lat", 64'(lat), 64'd33);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check_eq("ign_extra_done", 64'(cnt), 64'd0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd5;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("arst_done", {63'd0, bus.done}, 64'd0);
    check_eq("arst_hilo_en", {63'd0, bus.hilo_en}, 64'd0);
    check_eq("arst_hilo", bus.hilo_write, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check_eq("arst_no_done", 64'(cnt), 64'd0);
    run_op("post_rst", 2'b01, 32'd2, 32'd3, 0, res, dbz, lat, bcnt);
    check_eq("post_rst_res", res, 64'd6);

    // Back-to-back with Start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    d0 = -1;
    d1 = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d0 < 0) begin
          d0 = n;
          check_eq("b2b_res", bus.hilo_write, 64'd12);
        end else begin
          d1 = n;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_first", 64'(d0), 64'd33);
    check_eq("b2b_spacing", 64'(d1 - d0), 64'd34);
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
